// File: rtl/graph_mem_server_if.sv
// Request/response/load bundle between graph-memory requesters and the server.
interface graph_mem_server_if #(
  parameter int unsigned PROC_BITS = 4
);
  logic [1:0]             req_valid_in;
  logic [PROC_BITS+31:0]  req_msg_in0;
  logic [PROC_BITS+31:0]  req_msg_in1;
  logic [1:0]             req_ready_out;
  logic [1:0]             resp_valid_out;
  logic [PROC_BITS+31:0]  resp_msg_out0;
  logic [PROC_BITS+31:0]  resp_msg_out1;
  logic [1:0]             resp_ready_in;
  logic                   load_valid_in;
  logic [31:0]            load_addr_in;
  logic [31:0]            load_data_in;
  logic                   busy_out;

  modport master (
    output req_valid_in, req_msg_in0, req_msg_in1, resp_ready_in,
    output load_valid_in, load_addr_in, load_data_in,
    input  req_ready_out, resp_valid_out, resp_msg_out0, resp_msg_out1, busy_out
  );

  modport slave (
    input  req_valid_in, req_msg_in0, req_msg_in1, resp_ready_in,
    input  load_valid_in, load_addr_in, load_data_in,
    output req_ready_out, resp_valid_out, resp_msg_out0, resp_msg_out1, busy_out
  );
endinterface

// File: rtl/graph_mem_server.sv
// Graph-memory responder: two credit-limited request ports share one BRAM
// through a round-robin arbiter; tagged read data returns through per-port FIFOs.
module graph_mem_server #(
  parameter int unsigned PROC_BITS    = 4,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RESP_DEPTH   = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  graph_mem_server_if.slave bus
);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned MW   = PROC_BITS + 32;
  localparam int unsigned LAST = READ_LATENCY - 1;

  // Arbitration and credits
  logic [CW-1:0] credit_q [2];
  logic          rr_q;
  logic [1:0]    eligible;
  logic [1:0]    cand;
  logic [1:0]    grant;
  logic [1:0]    deq;
  logic          accept;
  logic [MW-1:0] sel_msg;
  logic [31:0]   sel_addr;
  logic          sel_oob;

  // Arbiter: loads own the BRAM, full-credit ports are masked, ties go to rr_q.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      eligible[p] = credit_q[p] < CW'(RESP_DEPTH);
    end
    cand  = bus.req_valid_in & eligible & {2{~bus.load_valid_in & ~rst_in}};
    grant = cand;
    if (cand == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end
  end

  assign accept   = |grant;
  assign sel_msg  = grant[1] ? bus.req_msg_in1 : bus.req_msg_in0;
  assign sel_addr = sel_msg[31:0];
  assign sel_oob  = sel_addr >= 32'(DEPTH);

  // Credit counters (in flight + queued) and round-robin pointer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      credit_q[0] <= '0;
      credit_q[1] <= '0;
      rr_q        <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        credit_q[p] <= credit_q[p] + CW'(grant[p]) - CW'(deq[p]);
      end
      if (grant[0]) begin
        rr_q <= 1'b1;
      end else if (grant[1]) begin
        rr_q <= 1'b0;
      end
    end
  end

  // Single-port BRAM; contents survive reset.
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  // Write on load, otherwise read for an accepted in-range request.
  always_ff @(posedge clk_in) begin
    if (bus.load_valid_in && (bus.load_addr_in < 32'(DEPTH))) begin
      mem[bus.load_addr_in[AW-1:0]] <= bus.load_data_in;
    end
    if (accept && !sel_oob) begin
      rd_q <= mem[sel_addr[AW-1:0]];
    end
  end

  // Request metadata travels alongside the BRAM read.
  logic                 pipe_valid_q [READ_LATENCY];
  logic                 pipe_port_q  [READ_LATENCY];
  logic                 pipe_oob_q   [READ_LATENCY];
  logic [PROC_BITS-1:0] pipe_tag_q   [READ_LATENCY];

  // Latency pipeline; only the valid bits need clearing on reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < int'(READ_LATENCY); k++) begin
        pipe_valid_q[k] <= 1'b0;
      end
    end else begin
      pipe_valid_q[0] <= accept;
      for (int k = 1; k < int'(READ_LATENCY); k++) begin
        pipe_valid_q[k] <= pipe_valid_q[k-1];
      end
    end
    pipe_port_q[0] <= grant[1];
    pipe_oob_q[0]  <= sel_oob;
    pipe_tag_q[0]  <= sel_msg[MW-1:32];
    for (int k = 1; k < int'(READ_LATENCY); k++) begin
      pipe_port_q[k] <= pipe_port_q[k-1];
      pipe_oob_q[k]  <= pipe_oob_q[k-1];
      pipe_tag_q[k]  <= pipe_tag_q[k-1];
    end
  end

  // BRAM output register is stage 0; extra latency adds plain delay stages.
  logic [31:0] out_raw;
  if (READ_LATENCY == 1) begin : g_no_dly
    assign out_raw = rd_q;
  end else begin : g_dly
    logic [31:0] dly_q [READ_LATENCY-1];
    // Data delay line matching the metadata pipeline.
    always_ff @(posedge clk_in) begin
      dly_q[0] <= rd_q;
      for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
    assign out_raw = dly_q[READ_LATENCY-2];
  end

  logic          out_valid;
  logic          out_port;
  logic [MW-1:0] out_msg;

  // Out-of-range reads return the list terminator (0).
  assign out_valid = pipe_valid_q[LAST];
  assign out_port  = pipe_port_q[LAST];
  assign out_msg   = {pipe_tag_q[LAST], pipe_oob_q[LAST] ? 32'h0 : out_raw};

  // Per-port response FIFOs; credits guarantee they never overflow.
  logic          head_valid [2];
  logic [MW-1:0] head_msg   [2];

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [MW-1:0] fifo_q [RESP_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          enq;

    assign enq = out_valid && (out_port == 1'(p));

    // Circular buffer with occupancy counter.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (enq) begin
          fifo_q[wr_ptr_q] <= out_msg;
          wr_ptr_q <= (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq[p]) begin
          rd_ptr_q <= (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_q <= count_q + CW'(enq) - CW'(deq[p]);
      end
    end

    assign head_valid[p] = count_q != '0;
    assign head_msg[p]   = fifo_q[rd_ptr_q];
  end

  // Dequeue happens on head valid and consumer ready.
  always_comb begin
    deq = 2'b00;
    for (int p = 0; p < 2; p++) begin
      deq[p] = bus.resp_ready_in[p] & head_valid[p];
    end
  end

  assign bus.req_ready_out  = grant;
  assign bus.resp_valid_out = {head_valid[1], head_valid[0]};
  assign bus.resp_msg_out0  = head_msg[0];
  assign bus.resp_msg_out1  = head_msg[1];
  assign bus.busy_out       = (credit_q[0] != '0) || (credit_q[1] != '0);
endmodule

// File: tb/tb_graph_mem_server.sv
// Directed bench for graph_mem_server: latency, arbitration, credits, loads,
// out-of-range reads and reset while reads are in flight.
module tb_graph_mem_server;
  localparam int unsigned PB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  graph_mem_server_if #(.PROC_BITS(PB)) bus ();

  graph_mem_server #(
    .PROC_BITS(PB), .DEPTH(1024), .READ_LATENCY(2), .RESP_DEPTH(4)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [35:0] resp_msg(input int p);
    return (p == 1) ? bus.resp_msg_out1 : bus.resp_msg_out0;
  endfunction

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_valid_in = 1'b1;
    bus.load_addr_in  = a;
    bus.load_data_in  = d;
    tick();
    bus.load_valid_in = 1'b0;
  endtask

  // Expects resp_ready_in[p]=1 so the observed head is consumed.
  task automatic wait_resp(input int p, input logic [35:0] exp, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      #1;
      if (bus.resp_valid_out[p]) begin
        check(tag, 64'(resp_msg(p)), 64'(exp));
        found = 1'b1;
      end
      tick();
    end
    if (!found) check({tag, "_timeout"}, 64'(found), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] exp_q [2][2];
    int          got_n [2];
    int          i0;
    int          i1;
    bit          seen;

    rst                = 1'b1;
    bus.req_valid_in   = 2'b11;
    bus.req_msg_in0    = '0;
    bus.req_msg_in1    = '0;
    bus.resp_ready_in  = 2'b00;
    bus.load_valid_in  = 1'b0;
    bus.load_addr_in   = '0;
    bus.load_data_in   = '0;

    // Reset state
    tick(); #1;
    check("rst_ready", 64'(bus.req_ready_out), 64'b00);
    check("rst_rvalid", 64'(bus.resp_valid_out), 64'b00);
    check("rst_busy", 64'(bus.busy_out), 64'd0);
    tick();
    rst = 1'b0;
    bus.req_valid_in = 2'b00;

    // Graph image
    load_word(0, 32'hDEAD_BEEF);
    load_word(10, 32'h0A0A_000A);
    load_word(11, 32'h0B0B_000B);
    load_word(20, 32'h1414_1414);
    load_word(21, 32'h1515_1515);
    for (int k = 0; k < 5; k++) load_word(30 + k, 32'h3000_0030 + k);
    load_word(6, 32'h6666_6666);
    load_word(5, 32'hAAAA_0001);
    load_word(6, 32'h0);

    // Basic read latency and tag
    bus.resp_ready_in = 2'b11;
    bus.req_valid_in  = 2'b01;
    bus.req_msg_in0   = {4'h3, 32'd5};
    #1 check("t1_grant_a", 64'(bus.req_ready_out), 64'b01);
    tick();
    bus.req_msg_in0 = {4'h4, 32'd6};
    #1 check("t1_grant_b", 64'(bus.req_ready_out), 64'b01);
    check("t1_busy", 64'(bus.busy_out), 64'd1);
    tick();
    bus.req_valid_in = 2'b00;
    #1 check("t1_early", 64'(bus.resp_valid_out[0]), 64'd0);
    tick(); #1;
    check("t1_valid_a", 64'(bus.resp_valid_out[0]), 64'd1);
    check("t1_msg_a", 64'(bus.resp_msg_out0), 64'({4'h3, 32'hAAAA_0001}));
    tick(); #1;
    check("t1_valid_b", 64'(bus.resp_valid_out[0]), 64'd1);
    check("t1_msg_b", 64'(bus.resp_msg_out0), 64'({4'h4, 32'h0}));
    tick(); #1;
    check("t1_drained", 64'(bus.resp_valid_out), 64'b00);
    check("t1_idle", 64'(bus.busy_out), 64'd0);
    tick();

    // Read-after-write
    load_word(8, 32'hBEEF_0008);
    bus.req_valid_in = 2'b01;
    bus.req_msg_in0  = {4'h7, 32'd8};
    #1 check("raw_grant", 64'(bus.req_ready_out), 64'b01);
    tick();
    bus.req_valid_in = 2'b00;
    wait_resp(0, {4'h7, 32'hBEEF_0008}, "raw_data");

    // Alternating grants from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q[0][0] = {4'h1, 32'h0A0A_000A};
    exp_q[0][1] = {4'h2, 32'h0B0B_000B};
    exp_q[1][0] = {4'h9, 32'h1414_1414};
    exp_q[1][1] = {4'hA, 32'h1515_1515};
    got_n[0] = 0;
    got_n[1] = 0;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 4) begin
        bus.req_valid_in = 2'b11;
        bus.req_msg_in0  = {4'(1 + i0), 32'(10 + i0)};
        bus.req_msg_in1  = {4'(9 + i1), 32'(20 + i1)};
      end else begin
        bus.req_valid_in = 2'b00;
      end
      #1;
      if (c < 4) begin
        check($sformatf("t2_grant%0d", c), 64'(bus.req_ready_out),
              (c % 2 == 0) ? 64'b01 : 64'b10);
        if (c % 2 == 0) i0++;
        else i1++;
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.resp_valid_out[p]) begin
          if (got_n[p] < 2) begin
            check($sformatf("t2_p%0d_resp%0d", p, got_n[p]), 64'(resp_msg(p)),
                  64'(exp_q[p][got_n[p]]));
          end
          got_n[p]++;
        end
      end
      tick();
    end
    check("t2_count_p0", 64'(got_n[0]), 64'd2);
    check("t2_count_p1", 64'(got_n[1]), 64'd2);

    // Credit limit on port 1
    bus.resp_ready_in = 2'b01;
    bus.req_valid_in  = 2'b10;
    for (int c = 0; c < 4; c++) begin
      bus.req_msg_in1 = {4'(c), 32'(30 + c)};
      #1 check($sformatf("t3_grant%0d", c), 64'(bus.req_ready_out), 64'b10);
      tick();
    end
    bus.req_msg_in1  = {4'h4, 32'd34};
    bus.req_valid_in = 2'b11;
    bus.req_msg_in0  = {4'h5, 32'd5};
    #1 check("t3_p0_served", 64'(bus.req_ready_out), 64'b01);
    tick();
    bus.req_valid_in = 2'b10;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("t3_blocked%0d", c), 64'(bus.req_ready_out), 64'b00);
      tick();
    end
    bus.resp_ready_in = 2'b11;
    #1;
    check("t3_deq_cycle", 64'(bus.req_ready_out), 64'b00);
    check("t3_head", 64'(bus.resp_msg_out1), 64'({4'h0, 32'h3000_0030}));
    tick();
    bus.resp_ready_in = 2'b01;
    #1 check("t3_one_more", 64'(bus.req_ready_out), 64'b10);
    tick();
    #1 check("t3_full_again", 64'(bus.req_ready_out), 64'b00);
    bus.req_valid_in  = 2'b00;
    bus.resp_ready_in = 2'b11;
    for (int k = 1; k < 5; k++) begin
      wait_resp(1, {4'(k), 32'h3000_0030 + 32'(k)}, $sformatf("t3_drain%0d", k));
    end
    tick(); #1;
    check("t3_idle", 64'(bus.busy_out), 64'd0);

    // Loads block reads
    bus.req_valid_in = 2'b11;
    bus.req_msg_in0  = {4'h1, 32'd10};
    bus.req_msg_in1  = {4'h2, 32'd20};
    bus.load_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.load_addr_in = 32'(40 + c);
      bus.load_data_in = {4{8'(8'h40 + c)}};
      #1 check($sformatf("t4_load%0d", c), 64'(bus.req_ready_out), 64'b00);
      tick();
    end
    bus.load_valid_in = 1'b0;
    #1 check("t4_resume", 64'(bus.req_ready_out), 64'b01);
    tick();
    bus.req_valid_in = 2'b00;
    wait_resp(0, {4'h1, 32'h0A0A_000A}, "t4_data");

    // Out-of-range read returns 0
    bus.req_valid_in = 2'b10;
    bus.req_msg_in1  = {4'hE, 32'd1024};
    #1 check("t5_grant", 64'(bus.req_ready_out), 64'b10);
    tick();
    bus.req_valid_in = 2'b00;
    wait_resp(1, {4'hE, 32'h0}, "t5_oob");
    bus.req_valid_in = 2'b01;
    bus.req_msg_in0  = {4'h6, 32'd42};
    tick();
    bus.req_valid_in = 2'b00;
    wait_resp(0, {4'h6, 32'h4242_4242}, "t5_loaded42");

    // Reset with two reads in flight
    bus.req_valid_in = 2'b01;
    bus.req_msg_in0  = {4'h1, 32'd5};
    #1 check("t6_grant_a", 64'(bus.req_ready_out), 64'b01);
    tick();
    bus.req_valid_in = 2'b10;
    bus.req_msg_in1  = {4'h2, 32'd6};
    #1 check("t6_grant_b", 64'(bus.req_ready_out), 64'b10);
    tick();
    rst = 1'b1;
    bus.req_valid_in = 2'b11;
    #1 check("t6_rst_ready", 64'(bus.req_ready_out), 64'b00);
    tick();
    rst = 1'b0;
    bus.req_valid_in = 2'b00;
    #1 check("t6_busy", 64'(bus.busy_out), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.resp_valid_out != 2'b00) seen = 1'b1;
      tick();
    end
    check("t6_no_resp", 64'(seen), 64'd0);
    bus.req_valid_in = 2'b01;
    bus.req_msg_in0  = {4'h9, 32'd5};
    tick();
    bus.req_valid_in = 2'b00;
    wait_resp(0, {4'h9, 32'hAAAA_0001}, "t6_preserved");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/graph_mem_server.md
Name: graph_mem_server

Overview:
Responder side of the graph-memory request protocol. Requesters such as the vertex fetch units send tagged read messages {proc_id, addr} on two independent request ports. The block arbitrates between them, reads a single-port graph BRAM with a fixed pipeline latency, and returns tagged data messages {proc_id, data} on the response port matching the request port. A separate load port writes the graph image (row/position/neighbor words) before traversal starts.

Parameters:
PROC_BITS, 4, width of the requester tag carried in request and response messages
DEPTH, 1024, number of 32-bit words in the graph BRAM
READ_LATENCY, 2, cycles from request acceptance to BRAM data available (fixed, at least 1)
RESP_DEPTH, 4, entries in each per-port response FIFO; also the per-port credit limit

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
req_valid_in[1:0]  input  2  request valid, one bit per port p
req_msg_in0 / req_msg_in1  input  PROC_BITS+32  {proc_id, addr}, addr in bits [31:0]
req_ready_out[1:0]  output  2  request accepted this cycle when valid and ready are both high
resp_valid_out[1:0]  output  2  response FIFO head valid
resp_msg_out0 / resp_msg_out1  output  PROC_BITS+32  {proc_id, data}
resp_ready_in[1:0]  input  2  consumer dequeues the head when valid and ready are both high
load_valid_in  input  1  write strobe
load_addr_in  input  32  write address
load_data_in  input  32  write data
busy_out  output  1  high while any request is in flight or any response FIFO is non-empty

Behaviour:
- Reset (synchronous, active-high):
  - Clears both response FIFOs, the latency pipeline, credit counters and the round-robin pointer (pointer value 0 = port 0 has priority).
  - Outputs during and after reset: req_ready_out=0 while rst_in is high; resp_valid_out=0; busy_out=0.
  - In-flight reads are dropped. BRAM contents are preserved.
- Credits:
  - credit[p] counts in-flight reads plus FIFO occupancy for port p, range 0..RESP_DEPTH.
  - Port p is eligible when credit[p] < RESP_DEPTH.
  - Acceptance increments credit[p]; a dequeue decrements it. A same-cycle accept and dequeue leave it unchanged.
- Arbitration:
  - At most one read is accepted per cycle.
  - When both ports are valid and eligible, the port at the round-robin pointer wins. After any grant the pointer moves to the other port.
  - A single valid, eligible port is granted regardless of the pointer.
  - req_ready_out is combinational and goes high only on the granted port.
  - When load_valid_in=1, the write takes the BRAM that cycle and req_ready_out=00.
- Read pipeline:
  - Data for a request accepted at cycle T is enqueued into resp FIFO p at the end of cycle T+READ_LATENCY, so resp_valid_out[p] rises at T+READ_LATENCY+1 if the FIFO was empty.
  - proc_id travels with the request unchanged.
  - addr >= DEPTH returns data 0 without a BRAM access. Requesters treat 0 as the list terminator.
- Ordering: responses within a port are returned in acceptance order. There is no ordering guarantee across ports.
- Read-after-write: a read accepted the cycle after a load write to the same address returns the new data.
- Response FIFO:
  - FIFOs never overflow, because of the credit limit.
  - The head is held stable while resp_ready_in[p]=0.
  - A dequeue from a full FIFO frees one credit the following cycle.
- Reset mid-traffic: responses whose requests were accepted before the reset never appear.

Test Plan:
- Load mem[5]=0xAAAA0001 and mem[6]=0; then port0 sends {4'h3, 5} at T -> resp_msg_out0={4'h3, 0xAAAA0001}, valid at T+3 (READ_LATENCY=2); the next read of addr 6 returns data 0.
- Both ports request every cycle with resp_ready=11 -> grants alternate 0,1,0,1 starting with port 0 after reset; each port returns its responses in order with correct tags.
- Port1 sends 4 requests with resp_ready_in[1]=0 -> req_ready_out[1] stays 0 after the 4th grant; port0 is still served; raising resp_ready_in[1] for one cycle admits exactly one more port1 request.
- load_valid_in=1 held for 3 cycles while both ports are valid -> req_ready_out=00 for those 3 cycles; reads resume on the following cycle.
- Read of addr DEPTH (1024) -> response data 0 with the correct tag.
- Assert rst_in for 1 cycle while 2 reads are in flight -> no response ever appears for them, busy_out=0 after reset, and earlier-loaded data is still readable.
